// File: rtl/window_burst_scheduler.sv
// Issues whole-image read bursts from the sample FIFO to the windower; fifo_rd one cycle after start, win_vld READ_LAT later.
// No backpressure inside a burst: a burst starts only with a full image buffered and a free downstream slot.
module window_burst_scheduler #(
    parameter int LOG2_IMG_SIZE   = 10,
    parameter int LOG2_FIFO_DEPTH = 12,
    parameter int READ_LAT        = 1,
    parameter int MAX_CREDITS     = 2
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     enable,
    input  logic [LOG2_FIFO_DEPTH:0] fifo_count,
    output logic                     fifo_rd,
    input  logic                     img_done,
    output logic                     win_vld,
    output logic                     sof,
    output logic                     eof,
    output logic [2:0]               credits,
    output logic                     busy,
    output logic                     credit_err,
    output logic [15:0]              img_issued
);
    localparam int unsigned IMG = 1 << LOG2_IMG_SIZE;
    localparam logic [LOG2_FIFO_DEPTH:0] IMG_CNT    = (LOG2_FIFO_DEPTH+1)'(IMG);
    localparam logic [LOG2_FIFO_DEPTH:0] IMG_CNT_P1 = (LOG2_FIFO_DEPTH+1)'(IMG + 1);
    localparam logic [LOG2_IMG_SIZE-1:0] LAST_BEAT  = '1;
    localparam logic [2:0]               MAX_CR     = 3'(MAX_CREDITS);

    typedef enum logic {IDLE, BURST} state_t;

    state_t                   state;
    logic [LOG2_IMG_SIZE-1:0] cntr;
    logic [LOG2_IMG_SIZE-1:0] cntr_inc;
    logic                     rd_first;
    logic                     rd_last;
    logic                     last_beat;
    logic                     start;
    logic                     pipe_any;

    // On the last beat the count still includes this cycle's pop, hence IMG+1.
    always_comb begin
        cntr_inc  = cntr + 1'b1;
        last_beat = (state == BURST) && (cntr == LAST_BEAT);
        start     = 1'b0;
        if (enable && credits != 3'd0) begin
            if (state == IDLE)
                start = fifo_count >= IMG_CNT;
            else if (last_beat)
                start = fifo_count >= IMG_CNT_P1;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state      <= IDLE;
            cntr       <= '0;
            fifo_rd    <= 1'b0;
            rd_first   <= 1'b0;
            rd_last    <= 1'b0;
            credits    <= MAX_CR;
            credit_err <= 1'b0;
            img_issued <= '0;
        end else begin
            if (start) begin
                state      <= BURST;
                fifo_rd    <= 1'b1;
                cntr       <= '0;
                rd_first   <= 1'b1;
                rd_last    <= 1'b0;
                img_issued <= img_issued + 16'd1;
            end else if (state == BURST && !last_beat) begin
                cntr     <= cntr_inc;
                rd_first <= 1'b0;
                rd_last  <= (cntr_inc == LAST_BEAT);
            end else begin
                state    <= IDLE;
                fifo_rd  <= 1'b0;
                cntr     <= '0;
                rd_first <= 1'b0;
                rd_last  <= 1'b0;
            end

            // A start and a returned image in the same cycle cancel out.
            if (start && !img_done)
                credits <= credits - 3'd1;
            else if (!start && img_done && credits != MAX_CR)
                credits <= credits + 3'd1;

            if (img_done && credits == MAX_CR)
                credit_err <= 1'b1;
        end
    end

    generate
        if (READ_LAT == 0) begin : g_nolat
            assign win_vld  = fifo_rd;
            assign sof      = rd_first;
            assign eof      = rd_last;
            assign pipe_any = 1'b0;
        end else begin : g_lat
            logic [2:0] stage [READ_LAT];

            always_ff @(posedge clk or negedge rst) begin
                if (!rst) begin
                    for (int i = 0; i < READ_LAT; i++)
                        stage[i] <= '0;
                end else begin
                    stage[0] <= {fifo_rd, rd_first, rd_last};
                    for (int i = 1; i < READ_LAT; i++)
                        stage[i] <= stage[i-1];
                end
            end

            assign {win_vld, sof, eof} = stage[READ_LAT-1];

            always_comb begin
                pipe_any = 1'b0;
                for (int i = 0; i < READ_LAT; i++)
                    pipe_any = pipe_any | stage[i][2];
            end
        end
    endgenerate

    assign busy = (state == BURST) || pipe_any;

endmodule

// File: tb/tb_window_burst_scheduler.sv
// Randomized bench for window_burst_scheduler: a countdown burst model predicts each cycle, a monitor scores the DUT.
module tb_window_burst_scheduler;
    localparam int L2I  = 3;
    localparam int L2F  = 5;
    localparam int RL   = 1;
    localparam int MAXC = 2;
    localparam int IMG  = 1 << L2I;

    logic           clk = 1'b0;
    logic           rst = 1'b0;
    logic           enable = 1'b0;
    logic           img_done = 1'b0;
    logic [L2F:0]   fifo_count = '0;
    logic           fifo_rd, win_vld, sof, eof, busy, credit_err;
    logic [2:0]     credits;
    logic [15:0]    img_issued;

    window_burst_scheduler #(
        .LOG2_IMG_SIZE  (L2I),
        .LOG2_FIFO_DEPTH(L2F),
        .READ_LAT       (RL),
        .MAX_CREDITS    (MAXC)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .enable    (enable),
        .fifo_count(fifo_count),
        .fifo_rd   (fifo_rd),
        .img_done  (img_done),
        .win_vld   (win_vld),
        .sof       (sof),
        .eof       (eof),
        .credits   (credits),
        .busy      (busy),
        .credit_err(credit_err),
        .img_issued(img_issued)
    );

    always #5 clk = ~clk;

    typedef struct {
        int cyc;
        bit sof;
        bit eof;
    } beat_t;

    beat_t exp_q[$];
    beat_t nb;
    beat_t hd;
    int    cyc    = 0;
    int    m_left = 0;      // beats of the current burst still to be read, including this cycle's
    int    m_cred = MAXC;
    int    m_iss  = 0;
    bit    m_err  = 1'b0;
    bit    m_start;
    bit    e_vld;
    bit    e_rd;
    int    n_vec  = 0;
    int    n_fail = 0;

    // Reference model: one image is IMG reads in a row; a new one may begin when the last ends.
    always @(posedge clk) begin
        cyc = cyc + 1;
        if (!rst) begin
            m_left = 0;
            m_cred = MAXC;
            m_iss  = 0;
            m_err  = 1'b0;
            exp_q.delete();
        end else begin
            if (m_left == 0)
                m_start = enable && m_cred > 0 && fifo_count >= IMG;
            else if (m_left == 1)
                m_start = enable && m_cred > 0 && fifo_count >= IMG + 1;
            else
                m_start = 1'b0;

            if (img_done && m_cred == MAXC)
                m_err = 1'b1;
            if (m_start && !img_done)
                m_cred = m_cred - 1;
            else if (!m_start && img_done && m_cred < MAXC)
                m_cred = m_cred + 1;

            if (m_start) begin
                m_left = IMG;
                m_iss  = (m_iss + 1) % 65536;
            end else if (m_left > 0) begin
                m_left = m_left - 1;
            end

            if (m_left > 0) begin
                nb.cyc = cyc + RL;
                nb.sof = (m_left == IMG);
                nb.eof = (m_left == 1);
                exp_q.push_back(nb);
            end
        end
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec = n_vec + 1;
        if (act !== exp) begin
            n_fail = n_fail + 1;
            $display("FAIL %s at cycle %0d: got %0d, expected %0d", name, cyc, act, exp);
        end
    endtask

    // Monitor: scores the DUT at every falling edge and just after any reset assertion.
    initial forever begin
        @(negedge clk or negedge rst);
        if (!rst) begin
            #1;
            chk("rst_fifo_rd",    fifo_rd,    0);
            chk("rst_win_vld",    win_vld,    0);
            chk("rst_sof",        sof,        0);
            chk("rst_eof",        eof,        0);
            chk("rst_busy",       busy,       0);
            chk("rst_credits",    credits,    MAXC);
            chk("rst_img_issued", img_issued, 0);
            chk("rst_credit_err", credit_err, 0);
        end else begin
            e_vld = exp_q.size() > 0 && exp_q[0].cyc == cyc;
            e_rd  = m_left > 0;
            chk("fifo_rd", fifo_rd, e_rd);
            chk("win_vld", win_vld, e_vld);
            if (e_vld) begin
                hd = exp_q.pop_front();
                chk("sof", sof, hd.sof);
                chk("eof", eof, hd.eof);
            end else begin
                chk("sof_idle", sof, 0);
                chk("eof_idle", eof, 0);
            end
            chk("busy",       busy,       e_rd || e_vld);
            chk("credits",    credits,    m_cred);
            chk("img_issued", img_issued, m_iss);
            chk("credit_err", credit_err, m_err);
        end
    end

    task automatic tick(input int n);
        repeat (n) begin
            @(negedge clk);
            #1;
        end
    endtask

    task automatic pulse_done();
        img_done = 1'b1;
        tick(1);
        img_done = 1'b0;
    endtask

    initial begin
        tick(3);
        enable = 1'b1;
        fifo_count = 8;
        rst = 1'b1;
        tick(24);

        fifo_count = 16;
        pulse_done(); tick(1); pulse_done();
        tick(24);

        fifo_count = 9;
        pulse_done(); tick(1); pulse_done();
        tick(24);

        fifo_count = 20;
        tick(4);
        pulse_done();
        tick(14);

        enable = 1'b0;
        repeat (3) pulse_done();
        tick(3);

        // Drop enable on beat 3; the burst must still complete.
        enable = 1'b1;
        fifo_count = 8;
        tick(1);
        tick(3);
        enable = 1'b0;
        tick(15);

        enable = 1'b1;
        fifo_count = 7;
        tick(10);

        for (int i = 0; i < 2500; i++) begin
            enable   = ($urandom_range(0, 7) != 0);
            img_done = ($urandom_range(0, 5) == 0);
            case ($urandom_range(0, 3))
                0:       fifo_count = 7;
                1:       fifo_count = 8;
                2:       fifo_count = 9;
                default: fifo_count = 6'($urandom_range(0, 63));
            endcase
            tick(1);
        end

        // Fresh burst after reset, then reset again on beat 5.
        img_done = 1'b0;
        rst = 1'b0;
        enable = 1'b1;
        fifo_count = 8;
        tick(2);
        rst = 1'b1;
        repeat (6) @(posedge clk);
        #2;
        rst = 1'b0;
        tick(2);
        rst = 1'b1;
        tick(20);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
        $finish;
    end

endmodule
